pipeline_core_fwd: RTL and testbench
====================================

Name: pipeline_core_fwd

Overview:
- Parametrised 5-stage (IF/ID/EX/MEM/WB) pipelined processor core; successor to the current fixed-width 20-bit pipeline top.
- Adds what that top lacks: data forwarding, load-use interlock, branch/jump resolution with flush, configurable data width and PC width.
- Sits between an external instruction ROM (combinational read) and the data memory (combinational read, synchronous write).

Parameters:
- DATA_W, 20, register/data-memory word width (>=12).
- PC_W, 8, program counter and instruction address width.
- REG_N, 16, number of architectural registers; fixed at 16 because register fields are 4 bits; R0 reads 0.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Iaddr  out  PC_W  instruction address (= PC).
- Idata  in  20  instruction word for Iaddr, same cycle.
- DataIn  in  DATA_W  data-memory read data for Daddress, same cycle.
- Daddress  out  DATA_W  data-memory address (MEM stage).
- Dout  out  DATA_W  data-memory write data (MEM stage).
- W  out  1  data-memory write enable; memory writes on the Clock edge while W=1.
- Stall  out  1  high during a load-use (or interlock) bubble cycle.
- Flush  out  1  high in the cycle a taken branch/jump squashes IF/ID and ID/EX.

Behaviour:
- Instruction format: op[19:16], a[15:12], b[11:8], c[7:4]. imm12 = [11:0]; imm8 = [7:0].
- Opcodes:
  - 0 NOP.
  - 1 LD: R[a] = mem[R[b]].
  - 2 ST: mem[R[b]] = R[a].
  - 3 ADD: R[a] = R[b]+R[c].
  - 4 SUB: R[a] = R[b]-R[c].
  - 5 AND: R[a] = R[b]&R[c].
  - 6 OR: R[a] = R[b]|R[c].
  - 7 MVI: R[a] = zero-extended imm12.
  - 8 BEQ: if R[a]==R[b], PC = PCbr+1+sext(imm8), else fall through.
  - 9 JMP: PC = imm12[PC_W-1:0].
  - 10-15: NOP.
- Arithmetic: modulo 2^DATA_W; no flags. PC wraps modulo 2^PC_W.
- Writes to R0 are discarded.
- Register file:
  - Written at the end of WB.
  - Same-cycle WB write is bypassed to the ID read (write-through).
- Forwarding to EX operands, priority EX/MEM > MEM/WB > register file.
  - Applies only when the producer writes a non-zero register matching the source.
  - A LD result is forwarded only from MEM/WB.
- Load-use interlock:
  - Condition: ID reads a register that a LD in EX will write.
  - PC and IF/ID hold; a NOP bubble enters ID/EX; Stall=1 for exactly 1 cycle.
- Branch/jump resolved in EX:
  - If taken, PC loads the target next edge, IF/ID and ID/EX become NOP, Flush=1 for 1 cycle.
  - Penalty: 2 cycles.
  - Not-taken: no penalty.
- Simultaneous Stall and Flush conditions: Flush wins; the stalled ID instruction is squashed.
- Latency:
  - Instruction fetched in cycle n writes its register at the end of cycle n+4.
  - A ST asserts W in cycle n+3.
- Reset (async, any time including mid-branch or mid-stall):
  - PC=0, Iaddr=0.
  - All pipeline registers become NOP.
  - W=0, Dout=0, Daddress=0, Stall=0, Flush=0.
  - All registers = 0.
  - First fetch from address 0 in the first cycle after Reset deasserts.
- W is only ever high for a ST in MEM. A ST squashed by Flush never asserts W.

Optional Feature:
- FORWARD_EN
  - Defined: forwarding paths as above; only load-use stalls.
  - Undefined: no EX forwarding; full interlock.
    - ID holds (bubble inserted, Stall=1) while any source register matches the destination of a valid non-R0 writer in EX or MEM.
    - WB→ID bypass is retained.
  - Architectural results identical in both builds; only cycle counts differ.

Test Plan:
- Reset → all outputs 0 and Iaddr=0.
  - Then execute MVI R1,5; MVI R2,7; ADD R3,R1,R2.
  - R3=12 at end of cycle 6 with FORWARD_EN; Stall never high.
- MVI R1,0x10; MVI R2,0xAB; ST R2,[R1] → W=1 with Daddress=0x10, Dout=0xAB in exactly one cycle.
- LD R4,[R1] (DataIn=0x55) immediately followed by ADD R5,R4,R4.
  - Stall=1 for one cycle; R5=0xAA.
- BEQ R0,R0,+3 at address 2.
  - Flush=1 one cycle; next Iaddr=6.
  - Instructions at 3,4 never write registers or assert W.
- JMP 0x00 at address 5 with ST at address 6 → W stays 0; PC returns to 0 and wraps correctly.
- Without FORWARD_EN, the first scenario:
  - Stall high 2 cycles before ADD enters EX.
  - R3=12, two cycles later than with forwarding.
- Assert Reset while Stall=1 → outputs 0 immediately (asynchronously); restart fetch from 0.

Source files
------------

// File: rtl/pipeline_core_fwd_if.sv
// Memory-side bundle of pipeline_core_fwd: instruction ROM fetch, data-memory access and
// pipeline status. master = core, slave = memory/environment.
interface pipeline_core_fwd_if #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned PC_W   = 8
);
  logic [PC_W-1:0]   iaddr;
  logic [19:0]       idata;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] daddress;
  logic [DATA_W-1:0] dout;
  logic              w;
  logic              stall;
  logic              flush;

  modport master (
    output iaddr, daddress, dout, w, stall, flush,
    input  idata, data_in
  );

  modport slave (
    input  iaddr, daddress, dout, w, stall, flush,
    output idata, data_in
  );
endinterface

// File: rtl/pipeline_core_fwd.sv
// 5-stage IF/ID/EX/MEM/WB core with branch resolution in EX and load-use interlock.
// Define FORWARD_EN for EX operand forwarding; otherwise ID interlocks on every RAW hazard.
module pipeline_core_fwd #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned REG_N  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pipeline_core_fwd_if.master bus_io
);
  localparam logic [3:0] OpLd = 4'd1, OpSt = 4'd2, OpAdd = 4'd3, OpSub = 4'd4, OpAnd = 4'd5;
  localparam logic [3:0] OpOr = 4'd6, OpMvi = 4'd7, OpBeq = 4'd8, OpJmp = 4'd9;

  typedef struct packed {
    logic [19:0]     instr;
    logic [PC_W-1:0] pc;
  } ifid_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [3:0]        rc;
    logic              we;
    logic [DATA_W-1:0] va;
    logic [DATA_W-1:0] vb;
    logic [DATA_W-1:0] vc;
    logic [11:0]       imm;
    logic [PC_W-1:0]   pc;
  } idex_t;

  typedef struct packed {
    logic              ld;
    logic              st;
    logic              we;
    logic [3:0]        rd;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exmem_t;

  typedef struct packed {
    logic              we;
    logic [3:0]        rd;
    logic [DATA_W-1:0] val;
  } memwb_t;

  logic [PC_W-1:0]   pc_q, pc_d;
  ifid_t             ifid_q, ifid_d;
  idex_t             idex_q, idex_d;
  exmem_t            exmem_q, exmem_d;
  memwb_t            memwb_q, memwb_d;
  logic [DATA_W-1:0] rf_q [REG_N];

  // use_v bits: {a, b, c}; writers never target R0, so R0 sources never hit
  function automatic logic src_hit(input logic [3:0] rd, input logic we, input logic [2:0] use_v,
                                   input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return we && ((use_v[2] && rd == a) || (use_v[1] && rd == b) || (use_v[0] && rd == c));
  endfunction

  logic [3:0]        id_op, id_ra, id_rb, id_rc;
  logic [2:0]        id_use;
  logic              id_we, ex_hit, stall_cond, taken;
  logic [DATA_W-1:0] id_va, id_vb, id_vc, ex_a, ex_b, ex_c, alu;
  logic [PC_W-1:0]   br_off, target;

  assign id_op  = ifid_q.instr[19:16];
  assign id_ra  = ifid_q.instr[15:12];
  assign id_rb  = ifid_q.instr[11:8];
  assign id_rc  = ifid_q.instr[7:4];
  assign id_use = {(id_op == OpSt) || (id_op == OpBeq),
                   id_op inside {OpLd, OpSt, OpAdd, OpSub, OpAnd, OpOr, OpBeq},
                   id_op inside {OpAdd, OpSub, OpAnd, OpOr}};
  assign id_we  = (id_op inside {OpLd, OpAdd, OpSub, OpAnd, OpOr, OpMvi}) && (id_ra != 4'd0);

  // Write-through: the value retiring in WB this cycle is visible to ID
  assign id_va = (memwb_q.we && memwb_q.rd == id_ra) ? memwb_q.val : rf_q[id_ra];
  assign id_vb = (memwb_q.we && memwb_q.rd == id_rb) ? memwb_q.val : rf_q[id_rb];
  assign id_vc = (memwb_q.we && memwb_q.rd == id_rc) ? memwb_q.val : rf_q[id_rc];

  assign ex_hit = src_hit(idex_q.ra, idex_q.we, id_use, id_ra, id_rb, id_rc);

`ifdef FORWARD_EN
  // Load data only exists after MEM, so a LD in EX/MEM is never a forwarding source
  function automatic logic [DATA_W-1:0] fwd(input logic [3:0] src, input logic [DATA_W-1:0] base,
                                            input exmem_t em, input memwb_t mw);
    if (em.we && !em.ld && em.rd == src) return em.res;
    if (mw.we && mw.rd == src) return mw.val;
    return base;
  endfunction

  assign stall_cond = ex_hit && (idex_q.op == OpLd);
  assign ex_a = fwd(idex_q.ra, idex_q.va, exmem_q, memwb_q);
  assign ex_b = fwd(idex_q.rb, idex_q.vb, exmem_q, memwb_q);
  assign ex_c = fwd(idex_q.rc, idex_q.vc, exmem_q, memwb_q);
`else
  assign stall_cond = ex_hit || src_hit(exmem_q.rd, exmem_q.we, id_use, id_ra, id_rb, id_rc);
  assign ex_a = idex_q.va;
  assign ex_b = idex_q.vb;
  assign ex_c = idex_q.vc;
`endif

  always_comb begin
    case (idex_q.op)
      OpAdd:   alu = ex_b + ex_c;
      OpSub:   alu = ex_b - ex_c;
      OpAnd:   alu = ex_b & ex_c;
      OpOr:    alu = ex_b | ex_c;
      OpMvi:   alu = DATA_W'(idex_q.imm);
      default: alu = '0;
    endcase
  end

  assign taken  = (idex_q.op == OpJmp) || ((idex_q.op == OpBeq) && (ex_a == ex_b));
  assign br_off = PC_W'($signed(idex_q.imm[7:0]));
  assign target = (idex_q.op == OpJmp) ? PC_W'(idex_q.imm) : idex_q.pc + PC_W'(1) + br_off;

  always_comb begin
    pc_d         = pc_q + PC_W'(1);
    ifid_d.instr = bus_io.idata;
    ifid_d.pc    = pc_q;
    idex_d.op    = id_op;
    idex_d.ra    = id_ra;
    idex_d.rb    = id_rb;
    idex_d.rc    = id_rc;
    idex_d.we    = id_we;
    idex_d.va    = id_va;
    idex_d.vb    = id_vb;
    idex_d.vc    = id_vc;
    idex_d.imm   = ifid_q.instr[11:0];
    idex_d.pc    = ifid_q.pc;
    // A taken branch squashes the stalled ID instruction too
    if (taken) begin
      pc_d   = target;
      ifid_d = '0;
      idex_d = '0;
    end else if (stall_cond) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = '0;
    end

    exmem_d.ld   = (idex_q.op == OpLd);
    exmem_d.st   = (idex_q.op == OpSt);
    exmem_d.we   = idex_q.we;
    exmem_d.rd   = idex_q.ra;
    exmem_d.res  = alu;
    exmem_d.addr = (exmem_d.ld || exmem_d.st) ? ex_b : '0;
    exmem_d.data = exmem_d.st ? ex_a : '0;

    memwb_d.we  = exmem_q.we;
    memwb_d.rd  = exmem_q.rd;
    memwb_d.val = exmem_q.ld ? bus_io.data_in : exmem_q.res;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      for (int unsigned i = 0; i < REG_N; i++) rf_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      if (memwb_q.we) rf_q[memwb_q.rd] <= memwb_q.val;
    end
  end

  assign bus_io.iaddr    = pc_q;
  assign bus_io.daddress = exmem_q.addr;
  assign bus_io.dout     = exmem_q.data;
  assign bus_io.w        = exmem_q.st;
  assign bus_io.stall    = stall_cond && !taken;
  assign bus_io.flush    = taken;
endmodule

// File: tb/tb_pipeline_core_fwd.sv
// Scoreboard bench for pipeline_core_fwd: expected stores and branch targets are queued as
// programs are loaded and retired against W / Iaddr as the core produces them.
module tb_pipeline_core_fwd;
  localparam int unsigned DATA_W = 20;
  localparam int unsigned PC_W   = 8;

`ifdef FORWARD_EN
  localparam int StallP1 = 0, StallP2 = 0, StallP3 = 1, StallP4 = 0, RfLag = 0;
`else
  localparam int StallP1 = 4, StallP2 = 2, StallP3 = 6, StallP4 = 2, RfLag = 2;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pipeline_core_fwd_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  pipeline_core_fwd #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_N(16)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  logic [19:0] rom [256];
  assign bus.idata   = rom[bus.iaddr];
  assign bus.data_in = (bus.daddress == DATA_W'(8'h10)) ? DATA_W'(8'h55) : '0;

  st_t             st_q [$];
  logic [PC_W-1:0] tgt_q [$];
  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int flush_cnt = 0;
  int w_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] mvi(input logic [3:0] a, input logic [11:0] imm);
    return {4'h7, a, imm};
  endfunction
  function automatic logic [19:0] alu(input logic [3:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 4'h0};
  endfunction
  function automatic logic [19:0] ldi(input logic [3:0] a, input logic [3:0] b);
    return {4'h1, a, b, 8'h00};
  endfunction
  function automatic logic [19:0] sti(input logic [3:0] a, input logic [3:0] b);
    return {4'h2, a, b, 8'h00};
  endfunction
  function automatic logic [19:0] beq(input logic [3:0] a, input logic [3:0] b,
                                      input logic [7:0] off);
    return {4'h8, a, b, off};
  endfunction

  // Monitor: retires expected stores and branch targets, counts status cycles
  initial begin
    logic flush_prev;
    st_t  e;
    flush_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        flush_prev = 1'b0;
        stall_cnt  = 0;
        flush_cnt  = 0;
        w_cnt      = 0;
      end else begin
        if (flush_prev) begin
          if (tgt_q.size() == 0) check_eq("flush_unexpected", 32'd1, 32'd0);
          else check_eq("flush_target", 32'(bus.iaddr), 32'(tgt_q.pop_front()));
        end
        flush_prev = bus.flush;
        if (bus.stall) stall_cnt++;
        if (bus.flush) flush_cnt++;
        if (bus.w) begin
          w_cnt++;
          if (st_q.size() == 0) begin
            check_eq("w_unexpected", 32'd1, 32'd0);
          end else begin
            e = st_q.pop_front();
            check_eq("st_addr", 32'(bus.daddress), 32'(e.addr));
            check_eq("st_data", 32'(bus.dout), 32'(e.data));
          end
        end
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 20'h0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_iaddr"}, 32'(bus.iaddr), 32'd0);
    check_eq({tag, "_w"}, 32'(bus.w), 32'd0);
    check_eq({tag, "_stall"}, 32'(bus.stall), 32'd0);
    check_eq({tag, "_flush"}, 32'(bus.flush), 32'd0);
    check_eq({tag, "_daddr"}, 32'(bus.daddress), 32'd0);
    check_eq({tag, "_dout"}, 32'(bus.dout), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    check_eq("first_fetch", 32'(bus.iaddr), 32'd0);
  endtask

  task automatic end_prog(input string tag, input int stalls, input int ws, input int flushes);
    check_eq({tag, "_stalls"}, 32'(stall_cnt), 32'(stalls));
    check_eq({tag, "_wcnt"}, 32'(w_cnt), 32'(ws));
    check_eq({tag, "_flushes"}, 32'(flush_cnt), 32'(flushes));
    check_eq({tag, "_st_left"}, 32'(st_q.size()), 32'd0);
    check_eq({tag, "_tgt_left"}, 32'(tgt_q.size()), 32'd0);
  endtask

  initial begin
    clear_rom();
    #1 rst = 1'b1;
    #2 check_outputs_zero("reset");

    // P1: forwarding chain into ADD, result stored to 0x20
    rom[0] = mvi(4'd1, 12'h005);
    rom[1] = mvi(4'd2, 12'h007);
    rom[2] = alu(4'h3, 4'd3, 4'd1, 4'd2);
    rom[3] = mvi(4'd6, 12'h020);
    rom[4] = sti(4'd3, 4'd6);
    st_q.push_back('{addr: 20'h20, data: 20'd12});
    do_reset();
    repeat (6 + RfLag) @(negedge clk);
    check_eq("p1_r3_early", 32'(dut.rf_q[3]), 32'd0);
    @(negedge clk);
    check_eq("p1_r3_written", 32'(dut.rf_q[3]), 32'd12);
    repeat (23) @(negedge clk);
    end_prog("p1", StallP1, 1, 0);

    // P2: single store, then a not-taken branch
    clear_rom();
    rom[0] = mvi(4'd1, 12'h010);
    rom[1] = mvi(4'd2, 12'h0AB);
    rom[2] = sti(4'd2, 4'd1);
    rom[3] = beq(4'd1, 4'd2, 8'h05);
    st_q.push_back('{addr: 20'h10, data: 20'hAB});
    do_reset();
    repeat (25) @(negedge clk);
    end_prog("p2", StallP2, 1, 0);

    // P3: load-use
    clear_rom();
    rom[0] = mvi(4'd1, 12'h010);
    rom[1] = ldi(4'd4, 4'd1);
    rom[2] = alu(4'h3, 4'd5, 4'd4, 4'd4);
    rom[3] = mvi(4'd7, 12'h030);
    rom[4] = sti(4'd5, 4'd7);
    st_q.push_back('{addr: 20'h30, data: 20'hAA});
    do_reset();
    repeat (30) @(negedge clk);
    end_prog("p3", StallP3, 1, 0);

    // P4: taken BEQ over squashed writers, JMP with a store shadow, PC wrap
    clear_rom();
    rom[0]  = mvi(4'd1, 12'h011);
    rom[2]  = beq(4'd0, 4'd0, 8'h03);
    rom[3]  = mvi(4'd8, 12'h099);
    rom[4]  = sti(4'd1, 4'd1);
    rom[5]  = sti(4'd1, 4'd1);
    rom[6]  = mvi(4'd9, 12'h040);
    rom[7]  = sti(4'd8, 4'd9);
    rom[8]  = {4'h9, 4'h0, 12'h0FD};
    rom[9]  = sti(4'd1, 4'd1);
    rom[10] = sti(4'd1, 4'd1);
    st_q.push_back('{addr: 20'h40, data: 20'h0});
    tgt_q.push_back(8'h06);
    tgt_q.push_back(8'hFD);
    do_reset();
    for (int i = 0; i < 60 && bus.iaddr != 8'hFF; i++) @(negedge clk);
    check_eq("p4_reach_ff", 32'(bus.iaddr), 32'hFF);
    @(negedge clk);
    check_eq("p4_wrap", 32'(bus.iaddr), 32'd0);
    end_prog("p4", StallP4, 1, 2);

    // P5: asynchronous reset while stalled, then restart
    clear_rom();
    rom[0] = mvi(4'd1, 12'h010);
    rom[1] = ldi(4'd4, 4'd1);
    rom[2] = alu(4'h3, 4'd5, 4'd4, 4'd4);
    rom[3] = mvi(4'd7, 12'h030);
    rom[4] = sti(4'd5, 4'd7);
    st_q.push_back('{addr: 20'h30, data: 20'hAA});
    do_reset();
    for (int i = 0; i < 20 && !bus.stall; i++) @(negedge clk);
    check_eq("p5_stall_seen", 32'(bus.stall), 32'd1);
    #1 rst = 1'b1;
    #1 check_outputs_zero("p5_async");
    do_reset();
    repeat (30) @(negedge clk);
    end_prog("p5", StallP3, 1, 0);

    // P6: ALU ops, modulo wrap, R0 discard, opcode 10 as NOP
    clear_rom();
    rom[0]  = mvi(4'd1, 12'h0F0);
    rom[1]  = mvi(4'd2, 12'h03C);
    rom[2]  = alu(4'h4, 4'd3, 4'd1, 4'd2);
    rom[3]  = alu(4'h5, 4'd4, 4'd1, 4'd2);
    rom[4]  = alu(4'h6, 4'd5, 4'd1, 4'd2);
    rom[5]  = alu(4'h4, 4'd6, 4'd2, 4'd1);
    rom[6]  = mvi(4'd0, 12'h077);
    rom[7]  = mvi(4'd7, 12'h050);
    rom[8]  = sti(4'd3, 4'd7);
    rom[9]  = sti(4'd4, 4'd7);
    rom[10] = sti(4'd5, 4'd7);
    rom[11] = sti(4'd6, 4'd7);
    rom[12] = sti(4'd0, 4'd7);
    rom[13] = {4'hA, 4'h1, 12'hFFF};
    rom[14] = sti(4'd1, 4'd7);
    st_q.push_back('{addr: 20'h50, data: 20'hB4});
    st_q.push_back('{addr: 20'h50, data: 20'h30});
    st_q.push_back('{addr: 20'h50, data: 20'hFC});
    st_q.push_back('{addr: 20'h50, data: 20'hFFF4C});
    st_q.push_back('{addr: 20'h50, data: 20'h0});
    st_q.push_back('{addr: 20'h50, data: 20'hF0});
    do_reset();
    repeat (50) @(negedge clk);
    check_eq("p6_wcnt", 32'(w_cnt), 32'd6);
    check_eq("p6_st_left", 32'(st_q.size()), 32'd0);
    check_eq("p6_flushes", 32'(flush_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
